// File: rtl/hazard_pkg.sv
// Shared types and match/priority helpers for the MIPS hazard tracker.
// Build option: HAZARD_W2D_FWD_EN (in hazard_tracker) enables W-to-D forwarding.
package hazard_pkg;

  localparam int TW = 2;
  localparam int RW = 5;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] FWDE_PIPE = 2'd0;
  localparam logic [1:0] FWDE_M    = 2'd1;
  localparam logic [1:0] FWDE_W    = 2'd2;

  localparam logic [TW-1:0] TUSE_NONE = TW'(3);

  typedef struct packed {
    logic [RW-1:0] dst;
    logic [TW-1:0] tnew;
  } ent_t;

  typedef struct packed {
    logic          hit;
    logic [TW-1:0] tnew;
    logic [1:0]    src;
  } prod_t;

  function automatic logic [TW-1:0] sat_dec(
    input logic [TW-1:0] x
  );
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  // Later assignments win, so the newest matching stage is kept.
  function automatic prod_t newest(
    input logic [RW-1:0] r,
    input ent_t          e,
    input ent_t          m,
    input ent_t          w,
    input logic          use_e,
    input logic          use_w
  );
    prod_t p;
    p = '0;
    if (r != '0) begin
      if (use_w && w.dst == r)
        p = '{hit: 1'b1, tnew: w.tnew, src: FWD_W};
      if (m.dst == r)
        p = '{hit: 1'b1, tnew: m.tnew, src: FWD_M};
      if (use_e && e.dst == r)
        p = '{hit: 1'b1, tnew: e.tnew, src: FWD_E};
    end
    return p;
  endfunction

  function automatic logic [1:0] d_sel(
    input prod_t         p,
    input logic [TW-1:0] tuse
  );
    if (tuse != TUSE_NONE && p.hit && p.tnew == '0)
      return p.src;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] e_sel(
    input prod_t p
  );
    logic [1:0] s;
    s = FWDE_PIPE;
    if (p.hit && p.tnew == '0) begin
      unique case (p.src)
        FWD_M:   s = FWDE_M;
        FWD_W:   s = FWDE_W;
        default: s = FWDE_PIPE;
      endcase
    end
    return s;
  endfunction

  function automatic logic need_stall(
    input prod_t         p,
    input logic [TW-1:0] tuse
  );
    return (tuse != TUSE_NONE) && p.hit && (p.tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One in-flight producer entry {dst, tnew} with saturating tnew decrement.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  ent_t d,
  output ent_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else
      q <= '{dst: d.dst, tnew: sat_dec(d.tnew)};
  end

endmodule

// File: rtl/hazard_tracker.sv
// Scoreboard and stall/forward controller for the five-stage pipeline.
// Define HAZARD_W2D_FWD_EN to let W forward to D (else regfile write-through).
module hazard_tracker #(
  parameter int TW = hazard_pkg::TW,
  parameter int RW = hazard_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] Tnew_E,
  input  logic [RW-1:0] Num_new_E,
  input  logic [RW-1:0] rs_D,
  input  logic [RW-1:0] rt_D,
  input  logic [TW-1:0] Tuse_rs_D,
  input  logic [TW-1:0] Tuse_rt_D,
  input  logic [RW-1:0] rs_E,
  input  logic [RW-1:0] rt_E,
  output logic          stall,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic [1:0]    fwd_rs_E,
  output logic [1:0]    fwd_rt_E,
  output logic [TW-1:0] Tnew_M
);

  import hazard_pkg::*;

`ifdef HAZARD_W2D_FWD_EN
  localparam logic W2D = 1'b1;
`else
  localparam logic W2D = 1'b0;
`endif

  ent_t e_ent;
  ent_t m_ent;
  ent_t w_ent;

  prod_t p_rs_d;
  prod_t p_rt_d;
  prod_t p_rs_e;
  prod_t p_rt_e;

  assign e_ent = '{dst: Num_new_E, tnew: Tnew_E};

  hazard_stage_reg u_m (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (e_ent),
    .q     (m_ent)
  );

  hazard_stage_reg u_w (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (m_ent),
    .q     (w_ent)
  );

  assign p_rs_d = newest(rs_D, e_ent, m_ent, w_ent, 1'b1, W2D);
  assign p_rt_d = newest(rt_D, e_ent, m_ent, w_ent, 1'b1, W2D);
  // E never forwards from itself.
  assign p_rs_e = newest(rs_E, e_ent, m_ent, w_ent, 1'b0, 1'b1);
  assign p_rt_e = newest(rt_E, e_ent, m_ent, w_ent, 1'b0, 1'b1);

  assign stall = need_stall(p_rs_d, Tuse_rs_D)
               | need_stall(p_rt_d, Tuse_rt_D);

  assign fwd_rs_D = d_sel(p_rs_d, Tuse_rs_D);
  assign fwd_rt_D = d_sel(p_rt_d, Tuse_rt_D);
  assign fwd_rs_E = e_sel(p_rs_e);
  assign fwd_rt_E = e_sel(p_rt_e);

  assign Tnew_M = m_ent.tnew;

endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized and directed bench for hazard_tracker with an age-based model.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Tnew_E;
  logic [4:0] Num_new_E;
  logic [4:0] rs_D, rt_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D;
  logic [4:0] rs_E, rt_E;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [1:0] Tnew_M;

  int errors = 0;
  int checks = 0;

  // Model history: E inputs captured one and two edges ago.
  int h1d, h1t, h2d, h2t;

`ifdef HAZARD_W2D_FWD_EN
  localparam bit W2D = 1'b1;
`else
  localparam bit W2D = 1'b0;
`endif

  hazard_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Tnew_E    (Tnew_E),
    .Num_new_E (Num_new_E),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .Tuse_rs_D (Tuse_rs_D),
    .Tuse_rt_D (Tuse_rt_D),
    .rs_E      (rs_E),
    .rt_E      (rt_E),
    .stall     (stall),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .fwd_rs_E  (fwd_rs_E),
    .fwd_rt_E  (fwd_rt_E),
    .Tnew_M    (Tnew_M)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  // D source: newest producer among E, M (and W if enabled).
  function automatic void ref_d(input int r, input int tuse,
                                output int st, output int sel);
    int dst[3];
    int tn[3];
    int n;
    bit found;
    st = 0;
    sel = 0;
    found = 1'b0;
    dst[0] = int'(Num_new_E); tn[0] = int'(Tnew_E);
    dst[1] = h1d;             tn[1] = sat(h1t - 1);
    dst[2] = h2d;             tn[2] = sat(h2t - 2);
    n = W2D ? 3 : 2;
    if (tuse != 3 && r != 0) begin
      for (int i = 0; i < n; i++) begin
        if (!found && dst[i] == r) begin
          found = 1'b1;
          st = (tn[i] > tuse) ? 1 : 0;
          sel = (tn[i] == 0) ? i + 1 : 0;
        end
      end
    end
  endfunction

  // E source: newest producer among M then W.
  function automatic int ref_e(input int r);
    int res;
    res = 0;
    if (r != 0) begin
      if (h1d == r)
        res = (sat(h1t - 1) == 0) ? 1 : 0;
      else if (h2d == r)
        res = (sat(h2t - 2) == 0) ? 2 : 0;
    end
    return res;
  endfunction

  task automatic set_idle();
    Tnew_E = 0; Num_new_E = 0;
    rs_D = 0; rt_D = 0;
    Tuse_rs_D = 3; Tuse_rt_D = 3;
    rs_E = 0; rt_E = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      h1d = 0; h1t = 0; h2d = 0; h2t = 0;
    end else begin
      h2d = h1d; h2t = h1t;
      h1d = int'(Num_new_E); h1t = int'(Tnew_E);
    end
    @(negedge clk);
  endtask

  task automatic flush();
    set_idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    Num_new_E = 8; Tnew_E = 2;
    tick();
    #1;
    checks++;
    if (Tnew_M !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_tnew_m got=%0d exp=1", Tnew_M);
    end
    rst_n = 1'b0;
    h1d = 0; h1t = 0; h2d = 0; h2t = 0;
    Num_new_E = 0; Tnew_E = 0;
    rs_D = 8; Tuse_rs_D = 2; rs_E = 8; rt_E = 8;
    #1;
    checks++;
    if (Tnew_M !== 2'd0) begin
      errors++;
      $display("FAIL reset_tnew_m got=%0d exp=0", Tnew_M);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%0d exp=0", stall);
    end
    checks++;
    if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'd0) begin
      errors++;
      $display("FAIL reset_fwd got=%0d,%0d,%0d,%0d exp=0", fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E);
    end
    tick();
    set_idle();
    rst_n = 1'b1;
    Num_new_E = 4; Tnew_E = 1;
    tick();
    Num_new_E = 0; Tnew_E = 0;
    #1;
    checks++;
    if (Tnew_M !== 2'd0) begin
      errors++;
      $display("FAIL release_tnew_m got=%0d exp=0", Tnew_M);
    end
    rs_E = 4;
    #1;
    checks++;
    if (fwd_rs_E !== 2'd1) begin
      errors++;
      $display("FAIL release_fwd_rs_e got=%0d exp=1", fwd_rs_E);
    end
  endtask

  task automatic test_lw_stall();
    flush();
    Num_new_E = 8; Tnew_E = 2; rs_D = 8; Tuse_rs_D = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL lw_stall got=%0d exp=1", stall);
    end
    tick();
    Num_new_E = 0; Tnew_E = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lw_release got=%0d exp=0", stall);
    end
    tick();
    rs_D = 0; Tuse_rs_D = 3; rs_E = 8;
    #1;
    checks++;
    if (fwd_rs_E !== 2'd2) begin
      errors++;
      $display("FAIL lw_fwd_rs_e got=%0d exp=2", fwd_rs_E);
    end
  endtask

  task automatic test_ori_beq();
    flush();
    Num_new_E = 9; Tnew_E = 1; rt_D = 9; Tuse_rt_D = 0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL beq_stall got=%0d exp=1", stall);
    end
    tick();
    Num_new_E = 0; Tnew_E = 0;
    #1;
    checks++;
    if (fwd_rt_D !== 2'd2 || stall !== 1'b0) begin
      errors++;
      $display("FAIL beq_fwd got=%0d/%0d exp=2/0", fwd_rt_D, stall);
    end
  endtask

  task automatic test_jal_jr();
    flush();
    Num_new_E = 31; Tnew_E = 0; rs_D = 31; Tuse_rs_D = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd1) begin
      errors++;
      $display("FAIL jr_fwd got=%0d/%0d exp=0/1", stall, fwd_rs_D);
    end
  endtask

  task automatic test_zero_reg();
    flush();
    Num_new_E = 0; Tnew_E = 2; rs_D = 0; Tuse_rs_D = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd0) begin
      errors++;
      $display("FAIL zero_reg got=%0d/%0d exp=0/0", stall, fwd_rs_D);
    end
  endtask

  task automatic test_priority();
    flush();
    Num_new_E = 5; Tnew_E = 1;
    tick();
    rs_D = 5; Tuse_rs_D = 1; rs_E = 5;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== 2'd0) begin
      errors++;
      $display("FAIL prio_tuse1 got=%0d/%0d exp=0/0", stall, fwd_rs_D);
    end
    checks++;
    if (fwd_rs_E !== 2'd1) begin
      errors++;
      $display("FAIL prio_fwd_rs_e got=%0d exp=1", fwd_rs_E);
    end
    Tuse_rs_D = 0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL prio_tuse0 got=%0d exp=1", stall);
    end
  endtask

  task automatic test_w2d();
    flush();
    Num_new_E = 7; Tnew_E = 0;
    tick();
    Num_new_E = 0;
    tick();
    rs_D = 7; Tuse_rs_D = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_rs_D !== (W2D ? 2'd3 : 2'd0)) begin
      errors++;
      $display("FAIL w2d got=%0d/%0d exp=0/%0d", stall, fwd_rs_D, W2D ? 3 : 0);
    end
  endtask

  task automatic test_random();
    int st_a, sel_a, st_b, sel_b;
    for (int c = 0; c < 400; c++) begin
      Num_new_E = 5'($urandom_range(0, 3));
      Tnew_E    = 2'($urandom_range(0, 3));
      rs_D      = 5'($urandom_range(0, 3));
      rt_D      = 5'($urandom_range(0, 3));
      Tuse_rs_D = 2'($urandom_range(0, 3));
      Tuse_rt_D = 2'($urandom_range(0, 3));
      rs_E      = 5'($urandom_range(0, 3));
      rt_E      = 5'($urandom_range(0, 3));
      #1;
      ref_d(int'(rs_D), int'(Tuse_rs_D), st_a, sel_a);
      ref_d(int'(rt_D), int'(Tuse_rt_D), st_b, sel_b);
      checks++;
      if (stall !== 1'((st_a | st_b) != 0)) begin
        errors++;
        $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", c, stall, st_a | st_b);
      end
      checks++;
      if (fwd_rs_D !== 2'(sel_a)) begin
        errors++;
        $display("FAIL rand_fwd_rs_d cyc=%0d got=%0d exp=%0d", c, fwd_rs_D, sel_a);
      end
      checks++;
      if (fwd_rt_D !== 2'(sel_b)) begin
        errors++;
        $display("FAIL rand_fwd_rt_d cyc=%0d got=%0d exp=%0d", c, fwd_rt_D, sel_b);
      end
      checks++;
      if (fwd_rs_E !== 2'(ref_e(int'(rs_E)))) begin
        errors++;
        $display("FAIL rand_fwd_rs_e cyc=%0d got=%0d exp=%0d", c, fwd_rs_E, ref_e(int'(rs_E)));
      end
      checks++;
      if (fwd_rt_E !== 2'(ref_e(int'(rt_E)))) begin
        errors++;
        $display("FAIL rand_fwd_rt_e cyc=%0d got=%0d exp=%0d", c, fwd_rt_E, ref_e(int'(rt_E)));
      end
      checks++;
      if (Tnew_M !== 2'(sat(h1t - 1))) begin
        errors++;
        $display("FAIL rand_tnew_m cyc=%0d got=%0d exp=%0d", c, Tnew_M, sat(h1t - 1));
      end
      tick();
    end
  endtask

  initial begin
    h1d = 0; h1t = 0; h2d = 0; h2t = 0;
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_lw_stall();
    test_ori_beq();
    test_jal_jr();
    test_zero_reg();
    test_priority();
    test_w2d();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Scoreboard and stall/forward controller for the five-stage MIPS pipeline. Each cycle it consumes the E-stage hazard descriptor (Tnew, destination register), ages it through M and W in internal registers, and compares all in-flight producers against the D-stage and E-stage source registers. It drives the pipeline stall and the forwarding multiplexer selects for D and E.

## Interface

Parameters:
- TW, 2, Tnew/Tuse width
- RW, 5, register-number width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- Tnew_E  in  TW  cycles until the E-stage result exists, from the E-stage hazard decoder
- Num_new_E  in  RW  E-stage destination register; 0 means no write
- rs_D, rt_D  in  RW  D-stage source registers
- Tuse_rs_D, Tuse_rt_D  in  TW  cycles until D needs each source; 3 means unused
- rs_E, rt_E  in  RW  E-stage source registers
- stall  out  1  freeze PC and F/D, bubble D/E
- fwd_rs_D, fwd_rt_D  out  2  source select for D: 0 regfile, 1 E, 2 M, 3 W
- fwd_rs_E, fwd_rt_E  out  2  source select for E: 0 pipeline value, 1 M, 2 W
- Tnew_M  out  TW  registered M-stage Tnew, for debug

## Operation

- Holds two entries, M and W. Each entry is {dst[RW], tnew[TW]}.
- On every clock edge, with no enable:
  - M ← {Num_new_E, sat_dec(Tnew_E)}
  - W ← {M.dst, sat_dec(M.tnew)}
  - sat_dec(x) = x − 1, floored at 0.
- On a stall the external D/E register inserts a bubble. The bubble decodes as Num_new_E = 0, so the next M entry is inert. The tracker needs no stall feedback.
- A producer matches register r when dst == r and r != 0. Register 0 never stalls and never forwards.
- Stall, combinational: for each D source with Tuse < 3, take the newest matching producer (E, then M, then W). Stall = 1 if any such producer has tnew > Tuse.
- D forwarding: select the newest matching producer with tnew == 0. If a newer match has tnew > 0, select 0; the stall covers that case.
- E forwarding: same rule over M, then W. E-stage self-production is excluded.
- The W-to-D path is conditional (see Configuration).

## Timing

- stall and all fwd_* outputs are combinational from the M/W registers and the current inputs. No added latency.
- Tnew_M is registered.
- Reset: while rst_n = 0, the M and W entries are cleared to {0, 0}. This holds immediately, asynchronously. All outputs then derive from the cleared state: stall = 0 when the E inputs are inert, fwd_* = 0, Tnew_M = 0.
- Reset asserted mid-operation discards in-flight entries. The first edge after release samples E normally.
- Simultaneous matches always resolve to the newest stage.
- Tnew saturates at 0 and never wraps.
- A Tuse value of 3 on a source disables every check for that source.

## Configuration

- HAZARD_W2D_FWD_EN defined: W is a candidate for D forwarding, fwd_rs_D/fwd_rt_D may be 3.
- Undefined: the regfile provides write-through. W is ignored for D forwarding and stall, and D selects never take value 3.
- E forwarding from W is unconditional.

## Structure

- Shared package holds:
  - TW and RW
  - forwarding-select constants FWD_RF, FWD_E, FWD_M, FWD_W
  - the TUSE_NONE = 3 constant
- Sub-module hazard_stage_reg: one {dst, tnew} entry with saturating decrement and async active-low clear. It is instantiated twice, for M and W.
- Match/priority logic is a function in the package.

## Test plan

- Reset while M holds {8, 1} → M/W cleared, Tnew_M = 0, stall = 0, all fwd = 0. Release, then Tnew_E = 1, Num_new_E = 4 → next cycle Tnew_M = 0.
- lw to $8 in E (Tnew_E = 2), add in D with rs_D = 8, Tuse_rs_D = 1 → stall = 1 for exactly one cycle. Next cycle, with a bubble in E, stall = 0. One cycle later rs_E = 8 gives fwd_rs_E = 2.
- ori to $9 in E (Tnew_E = 1), beq in D with rt_D = 9, Tuse_rt_D = 0 → stall = 1. Next cycle fwd_rt_D = 2 and stall = 0.
- jal in E (Tnew_E = 0, Num_new_E = 31), jr in D with rs_D = 31, Tuse 0 → stall = 0, fwd_rs_D = 1.
- Num_new_E = 0 with Tnew_E = 2, rs_D = 0, Tuse 0 → stall = 0, fwd_rs_D = 0.
- E writes $5 with Tnew 1, M writes $5 with Tnew 0, rs_D = 5, Tuse 1 → stall = 0, fwd_rs_D = 0 (E newest, not ready). With Tuse 0 → stall = 1.
